// File: rtl/reg_scoreboard_if.sv
// Issue/writeback port bundle between decode, writeback and the register scoreboard.
// The master is the pipeline side and the slave is the scoreboard.
interface reg_scoreboard_if #(
  parameter int NREGS = 32,
  parameter int CNT_W = 2
);
  logic               issue_valid;
  logic [4:0]         issue_rs;
  logic [4:0]         issue_rt;
  logic [4:0]         issue_rd;
  logic               issue_wr;
  logic               wb_valid;
  logic [4:0]         wb_reg;
  logic               flush;
  logic               stall;
  logic               issue_ack;
  logic [NREGS-1:0]   busy_vec;
  logic [CNT_W+4:0]   outstanding;
  logic               wb_err;

  modport master (
    output issue_valid, issue_rs, issue_rt, issue_rd, issue_wr,
    output wb_valid, wb_reg, flush,
    input  stall, issue_ack, busy_vec, outstanding, wb_err
  );

  modport slave (
    input  issue_valid, issue_rs, issue_rt, issue_rd, issue_wr,
    input  wb_valid, wb_reg, flush,
    output stall, issue_ack, busy_vec, outstanding, wb_err
  );
endinterface

// File: rtl/reg_scoreboard.sv
// Pending-write scoreboard for the register file: one saturating counter per
// register, RAW stall generation for decode, and a sticky writeback-underflow flag.
module reg_scoreboard #(
  parameter int NREGS = 32,
  parameter int CNT_W = 2
) (
  input logic              clk,
  input logic              rst,
  reg_scoreboard_if.slave  sb
);
  localparam int OW = CNT_W + 5;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] cnt_q [NREGS];
  logic [CNT_W-1:0] cnt_d [NREGS];
  logic [OW-1:0]    outstanding_q;
  logic [OW-1:0]    outstanding_d;
  logic             wb_err_q;
  logic             wb_err_d;

  logic [NREGS-1:0] busy;
  logic             rs_busy;
  logic             rt_busy;
  logic             rd_full;
  logic             stall;
  logic             ack;
  logic             inc;
  logic             wb_hit;
  logic             dec;
  logic             underflow;
  logic [OW-1:0]    cnt_sum;

  // Register 0 is never tracked, so its busy bit is forced low.
  always_comb begin
    busy = '0;
    for (int r = 1; r < NREGS; r++) begin
      busy[r] = (cnt_q[r] != '0);
    end
  end

  assign rs_busy   = busy[sb.issue_rs];
  assign rt_busy   = busy[sb.issue_rt];
  assign rd_full   = sb.issue_wr && (sb.issue_rd != 5'd0) && (cnt_q[sb.issue_rd] == CNT_MAX);
  assign stall     = sb.issue_valid && (rs_busy || rt_busy || rd_full);
  assign ack       = sb.issue_valid && !stall;
  assign inc       = ack && sb.issue_wr && (sb.issue_rd != 5'd0);
  assign wb_hit    = sb.wb_valid && (sb.wb_reg != 5'd0);
  assign dec       = wb_hit && (cnt_q[sb.wb_reg] != '0);
  assign underflow = wb_hit && (cnt_q[sb.wb_reg] == '0);

  // Increment is applied first so an inc/dec pair on one register nets to zero.
  always_comb begin
    for (int r = 0; r < NREGS; r++) begin
      cnt_d[r] = cnt_q[r];
    end
    outstanding_d = outstanding_q;
    wb_err_d      = wb_err_q;
    if (sb.flush) begin
      for (int r = 0; r < NREGS; r++) begin
        cnt_d[r] = '0;
      end
      outstanding_d = '0;
    end else begin
      if (inc) begin
        cnt_d[sb.issue_rd] = cnt_d[sb.issue_rd] + 1'b1;
      end
      if (dec) begin
        cnt_d[sb.wb_reg] = cnt_d[sb.wb_reg] - 1'b1;
      end
      outstanding_d = outstanding_q + OW'(inc) - OW'(dec);
      wb_err_d      = wb_err_q || underflow;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NREGS; r++) begin
        cnt_q[r] <= '0;
      end
      outstanding_q <= '0;
      wb_err_q      <= 1'b0;
    end else begin
      for (int r = 0; r < NREGS; r++) begin
        cnt_q[r] <= cnt_d[r];
      end
      outstanding_q <= outstanding_d;
      wb_err_q      <= wb_err_d;
    end
  end

  assign sb.stall       = stall;
  assign sb.issue_ack   = ack;
  assign sb.busy_vec    = busy;
  assign sb.outstanding = outstanding_q;
  assign sb.wb_err      = wb_err_q;

  always_comb begin
    cnt_sum = '0;
    for (int r = 0; r < NREGS; r++) begin
      cnt_sum = cnt_sum + OW'(cnt_q[r]);
    end
  end

  a_no_saturate: assert property (@(posedge clk) disable iff (rst)
    (inc && !sb.flush) |-> (cnt_q[sb.issue_rd] != CNT_MAX));

  a_outstanding_sum: assert property (@(posedge clk) disable iff (rst)
    outstanding_q == cnt_sum);

  a_reg0_idle: assert property (@(posedge clk) disable iff (rst)
    cnt_q[0] == '0);
endmodule

// File: tb/tb_reg_scoreboard.sv
// Self-checking bench for reg_scoreboard: directed vector table, hand-written
// reset/flush corner sequences, and a randomized run against a counter model.
module tb_reg_scoreboard;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  reg_scoreboard_if #(.NREGS(32), .CNT_W(2)) sb ();
  reg_scoreboard #(.NREGS(32), .CNT_W(2)) dut (.clk(clk), .rst(rst), .sb(sb));

  typedef struct {
    string       name;
    logic        iv;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic        iwr;
    logic        wv;
    logic [4:0]  wr;
    logic        fl;
    logic        st;
    logic [31:0] bz;
    logic [6:0]  outs;
    logic        err;
  } vec_t;

  typedef struct {
    string       name;
    logic [31:0] bz;
    logic [6:0]  outs;
    logic        err;
  } exp_t;

  exp_t q[$];
  vec_t tbl[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input string n, input logic iv, input logic [4:0] rs,
                              input logic [4:0] rt, input logic [4:0] rd, input logic iwr,
                              input logic wv, input logic [4:0] wr, input logic fl,
                              input logic st, input logic [31:0] bz, input logic [6:0] o,
                              input logic er);
    vec_t v;
    v.name = n; v.iv = iv; v.rs = rs; v.rt = rt; v.rd = rd; v.iwr = iwr;
    v.wv = wv; v.wr = wr; v.fl = fl; v.st = st; v.bz = bz; v.outs = o; v.err = er;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    sb.issue_valid = v.iv;
    sb.issue_rs    = v.rs;
    sb.issue_rt    = v.rt;
    sb.issue_rd    = v.rd;
    sb.issue_wr    = v.iwr;
    sb.wb_valid    = v.wv;
    sb.wb_reg      = v.wr;
    sb.flush       = v.fl;
  endtask

  // Drive at negedge, check combinational outputs, then compare registered state after the edge.
  task automatic step(input vec_t v);
    exp_t e;
    @(negedge clk);
    drive(v);
    #1;
    check({v.name, ".stall"}, 32'(sb.stall), 32'(v.st));
    check({v.name, ".ack"}, 32'(sb.issue_ack), 32'(v.iv & ~v.st));
    e.name = v.name; e.bz = v.bz; e.outs = v.outs; e.err = v.err;
    q.push_back(e);
    @(posedge clk);
    #1;
    if (q.size() == 0) begin
      check({v.name, ".queue"}, 32'd0, 32'd1);
    end else begin
      e = q.pop_front();
      check({e.name, ".busy_vec"}, sb.busy_vec, e.bz);
      check({e.name, ".outstanding"}, 32'(sb.outstanding), 32'(e.outs));
      check({e.name, ".wb_err"}, 32'(sb.wb_err), 32'(e.err));
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    drive(mk("rst", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  int          mcnt [32];
  int          mout;
  logic        merr;

  initial begin
    vec_t v;
    logic [31:0] mb;
    rst = 1'b1;
    drive(mk("init", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    #1;
    check("reset.stall", 32'(sb.stall), 32'd0);
    check("reset.busy_vec", sb.busy_vec, 32'd0);
    check("reset.outstanding", 32'(sb.outstanding), 32'd0);
    check("reset.wb_err", 32'(sb.wb_err), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    tbl.push_back(mk("idle",        0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0,   0, 0));
    tbl.push_back(mk("iss_rd5",     1, 0, 0, 5, 1, 0, 0, 0, 0, 32'h20,  1, 0));
    tbl.push_back(mk("raw_rs5",     1, 5, 1, 0, 0, 0, 0, 0, 1, 32'h20,  1, 0));
    tbl.push_back(mk("raw_hold",    1, 5, 1, 0, 0, 0, 0, 0, 1, 32'h20,  1, 0));
    tbl.push_back(mk("raw_wb5",     1, 5, 1, 0, 0, 1, 5, 0, 1, 32'h0,   0, 0));
    tbl.push_back(mk("raw_ack",     1, 5, 1, 0, 0, 0, 0, 0, 0, 32'h0,   0, 0));
    tbl.push_back(mk("waw7_a",      1, 0, 0, 7, 1, 0, 0, 0, 0, 32'h80,  1, 0));
    tbl.push_back(mk("waw7_b",      1, 0, 0, 7, 1, 0, 0, 0, 0, 32'h80,  2, 0));
    tbl.push_back(mk("waw7_c",      1, 0, 0, 7, 1, 0, 0, 0, 0, 32'h80,  3, 0));
    tbl.push_back(mk("waw7_full",   1, 0, 0, 7, 1, 0, 0, 0, 1, 32'h80,  3, 0));
    tbl.push_back(mk("waw7_max_wb", 1, 0, 0, 7, 1, 1, 7, 0, 1, 32'h80,  2, 0));
    tbl.push_back(mk("waw7_net0",   1, 0, 0, 7, 1, 1, 7, 0, 0, 32'h80,  2, 0));
    tbl.push_back(mk("drain7_a",    0, 0, 0, 0, 0, 1, 7, 0, 0, 32'h80,  1, 0));
    tbl.push_back(mk("drain7_b",    0, 0, 0, 0, 0, 1, 7, 0, 0, 32'h0,   0, 0));
    tbl.push_back(mk("rd0",         1, 0, 0, 0, 1, 0, 0, 0, 0, 32'h0,   0, 0));
    tbl.push_back(mk("wb0",         0, 0, 0, 0, 0, 1, 0, 0, 0, 32'h0,   0, 0));
    tbl.push_back(mk("underflow9",  0, 0, 0, 0, 0, 1, 9, 0, 0, 32'h0,   0, 1));
    tbl.push_back(mk("err_sticky",  0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0,   0, 1));
    tbl.push_back(mk("pend2",       1, 0, 0, 2, 1, 0, 0, 0, 0, 32'h4,   1, 1));
    tbl.push_back(mk("pend4",       1, 0, 0, 4, 1, 0, 0, 0, 0, 32'h14,  2, 1));
    tbl.push_back(mk("raw_rt4",     1, 0, 4, 0, 0, 0, 0, 0, 1, 32'h14,  2, 1));
    tbl.push_back(mk("flush_iss6",  1, 0, 0, 6, 1, 0, 0, 1, 0, 32'h0,   0, 1));
    tbl.push_back(mk("post_flush6", 1, 0, 0, 6, 1, 0, 0, 0, 0, 32'h40,  1, 1));
    tbl.push_back(mk("pend3",       1, 0, 0, 3, 1, 0, 0, 0, 0, 32'h48,  2, 1));

    foreach (tbl[i]) step(tbl[i]);

    // Asynchronous reset in the middle of a cycle, with a dependent issue waiting.
    @(negedge clk);
    drive(mk("rs6", 1, 6, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    #1;
    check("pre_rst.stall", 32'(sb.stall), 32'd1);
    #1;
    rst = 1'b1;
    #1;
    check("async_rst.busy_vec", sb.busy_vec, 32'd0);
    check("async_rst.outstanding", 32'(sb.outstanding), 32'd0);
    check("async_rst.wb_err", 32'(sb.wb_err), 32'd0);
    check("async_rst.stall", 32'(sb.stall), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    step(mk("flush_wb9",  0, 0, 0, 0, 0, 1, 9, 1, 0, 32'h0,   0, 0));
    step(mk("inc_uflow9", 1, 0, 0, 9, 1, 1, 9, 0, 0, 32'h200, 1, 1));

    // Randomized traffic checked against an independent counter model.
    do_reset();
    foreach (mcnt[r]) mcnt[r] = 0;
    mout = 0;
    merr = 1'b0;
    for (int n = 0; n < 600; n++) begin
      logic ack_m;
      v.name = $sformatf("rand%0d", n);
      v.iv   = ($urandom_range(0, 3) != 0);
      v.rs   = 5'($urandom_range(0, 7));
      v.rt   = 5'($urandom_range(0, 7));
      v.rd   = 5'($urandom_range(0, 7));
      v.iwr  = ($urandom_range(0, 3) != 0);
      v.wv   = ($urandom_range(0, 1) != 0);
      v.wr   = 5'($urandom_range(0, 7));
      v.fl   = ($urandom_range(0, 40) == 0);
      v.st   = v.iv && ((v.rs != 0 && mcnt[v.rs] > 0) || (v.rt != 0 && mcnt[v.rt] > 0) ||
                        (v.iwr && v.rd != 0 && mcnt[v.rd] == 3));
      ack_m  = v.iv && !v.st;
      if (v.fl) begin
        foreach (mcnt[r]) mcnt[r] = 0;
        mout = 0;
      end else begin
        int wb_before;
        wb_before = mcnt[v.wr];
        if (ack_m && v.iwr && v.rd != 0) begin
          mcnt[v.rd]++;
          mout++;
        end
        if (v.wv && v.wr != 0) begin
          if (wb_before > 0) begin
            mcnt[v.wr]--;
            mout--;
          end else begin
            merr = 1'b1;
          end
        end
      end
      mb = '0;
      for (int r = 1; r < 32; r++) mb[r] = (mcnt[r] > 0);
      v.bz   = mb;
      v.outs = 7'(mout);
      v.err  = merr;
      step(v);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
